// File: rtl/b_bus_port_ctrl_if.sv
// B-bus port interface: CPU-side access strobe and bus fields going in,
// decoded PPU/APU/WRAM strobes and the read-target selector coming out.
interface b_bus_port_ctrl_if #(
    parameter int WRAM_AW   = 17,
    parameter int APU_PORTS = 4
);
    localparam int APW = (APU_PORTS > 1) ? $clog2(APU_PORTS) : 1;

    logic               acc_en;
    logic [7:0]         b_addr;
    logic               b_write;
    logic               b_read;
    logic [7:0]         b_wdata;

    logic [1:0]         read_target;
    logic [5:0]         ppu_sel;
    logic               ppu_we;
    logic               ppu_re;
    logic [APW-1:0]     apu_port;
    logic               apu_we;
    logic               apu_re;
    logic [WRAM_AW-1:0] wram_addr;
    logic               wram_we;
    logic               wram_re;
    logic [7:0]         wram_wdata;
    logic               slhv_pulse;

    modport master (
        output acc_en, b_addr, b_write, b_read, b_wdata,
        input  read_target, ppu_sel, ppu_we, ppu_re, apu_port, apu_we, apu_re,
               wram_addr, wram_we, wram_re, wram_wdata, slhv_pulse
    );

    modport slave (
        input  acc_en, b_addr, b_write, b_read, b_wdata,
        output read_target, ppu_sel, ppu_we, ppu_re, apu_port, apu_we, apu_re,
               wram_addr, wram_we, wram_re, wram_wdata, slhv_pulse
    );
endinterface

// File: rtl/b_bus_port_ctrl.sv
// B-bus address decoder: steers each strobed access to the PPU register file,
// the APU I/O ports, the counter-latch strobe or the auto-incrementing WRAM
// data port. All outputs are registered, one cycle after the acc_en strobe.
module b_bus_port_ctrl #(
    parameter int         WRAM_AW   = 17,
    parameter int         APU_PORTS = 4,
    parameter logic [7:0] APU_BASE  = 8'h40
) (
    input logic              clk,
    input logic              reset,
    b_bus_port_ctrl_if.slave bus
);
    localparam int APW = (APU_PORTS > 1) ? $clog2(APU_PORTS) : 1;

    localparam logic [1:0] RT_CART = 2'd0;
    localparam logic [1:0] RT_PPU  = 2'd1;
    localparam logic [1:0] RT_APU  = 2'd2;
    localparam logic [1:0] RT_WRAM = 2'd3;

    logic [WRAM_AW-1:0] waddr_q, waddr_d;
    logic [1:0]         read_target_q, read_target_d;
    logic [5:0]         ppu_sel_q, ppu_sel_d;
    logic               ppu_we_q, ppu_we_d;
    logic               ppu_re_q, ppu_re_d;
    logic [APW-1:0]     apu_port_q, apu_port_d;
    logic               apu_we_q, apu_we_d;
    logic               apu_re_q, apu_re_d;
    logic [WRAM_AW-1:0] wram_addr_q, wram_addr_d;
    logic               wram_we_q, wram_we_d;
    logic               wram_re_q, wram_re_d;
    logic [7:0]         wram_wdata_q, wram_wdata_d;
    logic               slhv_q, slhv_d;

    // Write wins when both direction bits are set.
    logic is_wr, is_rd;
    assign is_wr = bus.b_write;
    assign is_rd = bus.b_read & ~bus.b_write;

    // Decode the current access into next-state strobes and held fields.
    always_comb begin
        waddr_d       = waddr_q;
        read_target_d = RT_CART;
        ppu_sel_d     = ppu_sel_q;
        ppu_we_d      = 1'b0;
        ppu_re_d      = 1'b0;
        apu_port_d    = apu_port_q;
        apu_we_d      = 1'b0;
        apu_re_d      = 1'b0;
        wram_addr_d   = wram_addr_q;
        wram_we_d     = 1'b0;
        wram_re_d     = 1'b0;
        wram_wdata_d  = wram_wdata_q;
        slhv_d        = 1'b0;

        if (bus.acc_en) begin
            if (bus.b_addr <= 8'h33) begin
                // Write-only PPU registers.
                if (is_wr) begin
                    ppu_we_d  = 1'b1;
                    ppu_sel_d = bus.b_addr[5:0];
                end
            end else if (bus.b_addr <= 8'h3F) begin
                // Read-only PPU registers; 0x37 is the H/V counter latch,
                // which only produces a pulse and reads back as open bus.
                if (is_rd) begin
                    if (bus.b_addr == 8'h37) begin
                        slhv_d = 1'b1;
                    end else begin
                        ppu_re_d      = 1'b1;
                        ppu_sel_d     = bus.b_addr[5:0];
                        read_target_d = RT_PPU;
                    end
                end
            end else if (bus.b_addr[7:6] == APU_BASE[7:6]) begin
                // The APU ports mirror across the whole 64-byte window.
                if (is_wr || is_rd) begin
                    apu_port_d = bus.b_addr[APW-1:0];
                    apu_we_d   = is_wr;
                    apu_re_d   = is_rd;
                    if (is_rd) read_target_d = RT_APU;
                end
            end else begin
                case (bus.b_addr)
                    8'h80: begin
                        if (is_wr || is_rd) begin
                            wram_addr_d = waddr_q;
                            wram_we_d   = is_wr;
                            wram_re_d   = is_rd;
                            if (is_wr) wram_wdata_d = bus.b_wdata;
                            if (is_rd) read_target_d = RT_WRAM;
                            waddr_d = waddr_q + WRAM_AW'(1);
                        end
                    end
                    8'h81: if (is_wr) waddr_d[7:0]  = bus.b_wdata;
                    8'h82: if (is_wr) waddr_d[15:8] = bus.b_wdata;
                    8'h83: if (is_wr) waddr_d[WRAM_AW-1:16] = bus.b_wdata[WRAM_AW-17:0];
                    default: ;
                endcase
            end
        end
    end

    // Register all decode results; reset clears everything, including waddr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            waddr_q       <= '0;
            read_target_q <= RT_CART;
            ppu_sel_q     <= '0;
            ppu_we_q      <= 1'b0;
            ppu_re_q      <= 1'b0;
            apu_port_q    <= '0;
            apu_we_q      <= 1'b0;
            apu_re_q      <= 1'b0;
            wram_addr_q   <= '0;
            wram_we_q     <= 1'b0;
            wram_re_q     <= 1'b0;
            wram_wdata_q  <= '0;
            slhv_q        <= 1'b0;
        end else begin
            waddr_q       <= waddr_d;
            read_target_q <= read_target_d;
            ppu_sel_q     <= ppu_sel_d;
            ppu_we_q      <= ppu_we_d;
            ppu_re_q      <= ppu_re_d;
            apu_port_q    <= apu_port_d;
            apu_we_q      <= apu_we_d;
            apu_re_q      <= apu_re_d;
            wram_addr_q   <= wram_addr_d;
            wram_we_q     <= wram_we_d;
            wram_re_q     <= wram_re_d;
            wram_wdata_q  <= wram_wdata_d;
            slhv_q        <= slhv_d;
        end
    end

    assign bus.read_target = read_target_q;
    assign bus.ppu_sel     = ppu_sel_q;
    assign bus.ppu_we      = ppu_we_q;
    assign bus.ppu_re      = ppu_re_q;
    assign bus.apu_port    = apu_port_q;
    assign bus.apu_we      = apu_we_q;
    assign bus.apu_re      = apu_re_q;
    assign bus.wram_addr   = wram_addr_q;
    assign bus.wram_we     = wram_we_q;
    assign bus.wram_re     = wram_re_q;
    assign bus.wram_wdata  = wram_wdata_q;
    assign bus.slhv_pulse  = slhv_q;
endmodule

// File: doc/b_bus_port_ctrl.md
B_BUS_PORT_CTRL -- requirements
Module: b_bus_port_ctrl

Interface
REQ-001 SHALL have parameter WRAM_AW, default 17, meaning the WRAM port address width (legal range 17..24).
REQ-002 SHALL have parameter APU_PORTS, default 4, meaning the number of APU I/O ports (legal values 2 or 4).
REQ-003 SHALL have parameter APU_BASE, default 8'h40, meaning the base of the 64-byte APU window (low 6 bits zero).
REQ-004 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port acc_en, input, 1, one-cycle strobe marking a B-bus access; one access per strobe.
REQ-007 SHALL have port b_addr, input, 8, B-bus address.
REQ-008 SHALL have ports b_write and b_read, input, 1 each, access direction (write has priority).
REQ-009 SHALL have port b_wdata, input, 8, write data.
REQ-010 SHALL have port read_target, output, 2, where 0 = CART, 1 = PPU, 2 = APU, 3 = WRAM.
REQ-011 SHALL have ports ppu_sel (output, 6, register index b_addr[5:0]), ppu_we (output, 1) and ppu_re (output, 1).
REQ-012 SHALL have ports apu_port (output, $clog2(APU_PORTS)), apu_we (output, 1) and apu_re (output, 1).
REQ-013 SHALL have ports wram_addr (output, WRAM_AW), wram_we (output, 1), wram_re (output, 1) and wram_wdata (output, 8).
REQ-014 SHALL have port slhv_pulse, output, 1, the counter-latch strobe.

Function
REQ-015 SHALL decode only when acc_en=1; without acc_en, strobe outputs are 0 and no state changes.
REQ-016 SHALL register all outputs, giving 1-cycle latency from the acc_en cycle; strobes are single-cycle pulses.
REQ-017 SHALL treat a write to 8'h00..8'h33 as ppu_we=1 with ppu_sel=b_addr[5:0].
REQ-018 SHALL treat a read of 8'h34..8'h3F, excluding 8'h37, as ppu_re=1 with read_target=1.
REQ-019 SHALL treat a read of 8'h37 as slhv_pulse=1 with read_target=0; a write to 8'h37 has no effect.
REQ-020 SHALL map any access in APU_BASE..APU_BASE+63 to apu_port=b_addr[$clog2(APU_PORTS)-1:0], firing apu_we or apu_re; reads set read_target=2.
REQ-021 SHALL hold a WRAM_AW-bit address register waddr, written through the WMADDL/M/H registers:
- WMADDL (8'h81) loads waddr[7:0].
- WMADDM (8'h82) loads waddr[15:8].
- WMADDH (8'h83) loads waddr[WRAM_AW-1:16] from b_wdata low bits; unused bits are ignored.
REQ-022 SHALL treat an access to WMDATA (8'h80) as follows:
- The access uses the current waddr (wram_addr=waddr, wram_we/re=1); reads set read_target=3.
- waddr then increments by 1, modulo 2^WRAM_AW.
REQ-023 SHALL treat a write to WMDATA as wram_wdata=b_wdata, and a read of 8'h81..8'h83 as read_target=0 with no strobe.
REQ-024 SHALL treat any other address, or an access with neither b_write nor b_read, as read_target=0, all strobes 0 and no state change.
REQ-025 SHALL, when b_write=1 and b_read=1, perform the write only.
REQ-026 SHALL hold wram_addr, ppu_sel, apu_port and wram_wdata at their last values when no access occurs.

Reset
REQ-027 SHALL, on reset assertion, asynchronously clear waddr, all strobes, read_target, ppu_sel, apu_port, wram_addr and wram_wdata to 0.
REQ-028 SHALL discard any access pending at a reset asserted mid-operation; the first access after release is decoded normally.

Verification
REQ-029 SHALL cover: writes 81=34, 82=12, 83=01, then a WMDATA write of AA -> wram_addr=17'h11234, wram_we=1, then waddr=17'h11235.
REQ-030 SHALL cover: waddr=17'h1FFFF, then a WMDATA read -> wram_addr=17'h1FFFF, read_target=3, then waddr=0 (wrap).
REQ-031 SHALL cover: APU_PORTS=2, a read of 8'h47 -> apu_port=1, apu_re=1, read_target=2; APU_PORTS=4 -> apu_port=3.
REQ-032 SHALL cover: a read of 8'h37 -> slhv_pulse=1, read_target=0; a read of 8'h38 -> ppu_re=1, ppu_sel=6'h38.
REQ-033 SHALL cover: b_write=1 and b_read=1 together at 8'h80 -> wram_we=1, wram_re=0, single increment.
REQ-034 SHALL cover: reset asserted between acc_en and the following edge -> no strobe, waddr=0.
